decodificador_display: RTL and testbench



---
 rtl/decodificador_display_if.sv | 26 ++
 rtl/decodificador_display.sv | 93 +++++++++
 tb/tb_decodificador_display.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/decodificador_display_if.sv
// Handshake bundle between a segment-code producer and the seven-segment decoder.
// The slave modport is the decoder's view; master is the producer/consumer side.
interface decodificador_display_if #(
   parameter int NDIG = 4
) ();
   localparam int CW = $clog2(NDIG + 1);

   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_code;
   logic              out_valid;
   logic              out_ready;
   logic [4*NDIG-1:0] out_bcd;
   logic [CW-1:0]     out_count;
   logic              out_err;

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_bcd, out_count, out_err
   );

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_bcd, out_count, out_err
   );
endinterface

// File: rtl/decodificador_display.sv
// Seven-segment decoder: maps segment codes back to BCD digits and packs them
// into a multi-digit word, terminated by the dp bit or by filling NDIG digits.
module decodificador_display #(
   parameter int NDIG = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   decodificador_display_if.slave bus
);
   localparam int CW = $clog2(NDIG + 1);

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t            state_reg;
   logic              in_ready_reg;
   logic              out_valid_reg;
   logic [4*NDIG-1:0] shift_reg;
   logic [4*NDIG-1:0] shift_next;
   logic [CW-1:0]     cnt_reg;
   logic [CW-1:0]     cnt_next;
   logic              err_reg;
   logic [3:0]        digit;
   logic              invalid;
   logic              accept;
   logic              last;

   always_comb begin
      digit   = 4'hF;
      invalid = 1'b0;
      case (bus.in_code[6:0])
         7'h3F: digit = 4'd0;
         7'h06: digit = 4'd1;
         7'h5B: digit = 4'd2;
         7'h4F: digit = 4'd3;
         7'h66: digit = 4'd4;
         7'h6D: digit = 4'd5;
         7'h7D: digit = 4'd6;
         7'h07: digit = 4'd7;
         7'h7F: digit = 4'd8;
         7'h6F: digit = 4'd9;
         default: invalid = 1'b1;
      endcase
   end

   // Newest digit enters at [3:0]; older digits move up one nibble.
   assign shift_next[3:0] = digit;
   generate
      for (genvar gi = 1; gi < NDIG; gi++) begin : g_shift
         assign shift_next[4*gi +: 4] = shift_reg[4*(gi-1) +: 4];
      end
   endgenerate

   assign cnt_next = cnt_reg + CW'(1);
   assign accept   = bus.in_valid & in_ready_reg;
   assign last     = bus.in_code[7] | (cnt_next == CW'(NDIG));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ACC;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         shift_reg     <= '0;
         cnt_reg       <= '0;
         err_reg       <= 1'b0;
      end else if (state_reg == ACC) begin
         if (accept) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_reg | invalid;
            if (last) begin
               state_reg     <= HOLD;
               in_ready_reg  <= 1'b0;
               out_valid_reg <= 1'b1;
            end
         end
      end else begin
         if (bus.out_ready) begin
            state_reg     <= ACC;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            shift_reg     <= '0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_bcd   = shift_reg;
   assign bus.out_count = cnt_reg;
   assign bus.out_err   = err_reg;
endmodule

// File: tb/tb_decodificador_display.sv
// Self-checking bench for decodificador_display: a queue-based word model checked
// every cycle, plus directed vectors with hand-computed literal results.
module tb_decodificador_display;
   localparam int NDIG = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   decodificador_display_if #(.NDIG(NDIG)) bus ();

   decodificador_display #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: digits of the current word in arrival order, plus hold/error flags
   bit m_hold;
   bit m_err;
   int m_dig[$];

   function automatic int map_code(input logic [6:0] s);
      logic [6:0] tbl [10];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      for (int k = 0; k < 10; k++)
         if (tbl[k] == s) return k;
      return -1;
   endfunction

   function automatic logic [31:0] model_bcd();
      logic [31:0] v;
      v = 0;
      foreach (m_dig[k]) v = (v << 4) | m_dig[k];
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold = 0; m_err = 0; m_dig.delete();
      end else if (m_hold) begin
         if (bus.out_ready) begin
            m_hold = 0; m_err = 0; m_dig.delete();
         end
      end else if (bus.in_valid) begin
         int d;
         d = map_code(bus.in_code[6:0]);
         m_dig.push_back(d < 0 ? 15 : d);
         if (d < 0) m_err = 1;
         if (bus.in_code[7] || m_dig.size() == NDIG) m_hold = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_in_ready", 32'(bus.in_ready), 32'(!m_hold));
         chk("model_out_valid", 32'(bus.out_valid), 32'(m_hold));
         chk("model_out_bcd", 32'(bus.out_bcd), model_bcd());
         chk("model_out_count", 32'(bus.out_count), 32'(m_dig.size()));
         chk("model_out_err", 32'(bus.out_err), 32'(m_err));
      end
   end

   // Called at a negedge; returns at the negedge after the code was accepted
   task automatic push(input logic [7:0] c);
      int n;
      bus.in_valid = 1'b1;
      bus.in_code  = c;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_word(input string name, input logic [15:0] bcd,
                              input int cnt, input bit err);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_bcd"}, 32'(bus.out_bcd), 32'(bcd));
      chk({name, "_count"}, 32'(bus.out_count), 32'(cnt));
      chk({name, "_err"}, 32'(bus.out_err), 32'(err));
   endtask

   logic [15:0] held_bcd;
   logic [2:0]  held_cnt;
   int          n_ok;
   logic [7:0]  code;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_code   = 8'h00;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_count", 32'(bus.out_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full word 1234, released immediately
      push(8'h06); push(8'h5B); push(8'h4F); push(8'h66);
      expect_word("full", 16'h1234, 4, 1'b0);
      @(negedge clk);
      chk("full_bubble_valid", 32'(bus.out_valid), 32'd0);
      chk("full_bubble_ready", 32'(bus.in_ready), 32'd1);

      // Reset mid-word after 2 digits
      push(8'h06); push(8'h5B);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midreset_out_count", 32'(bus.out_count), 32'd0);
      chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Short word via dp
      push(8'h6D); push(8'hFD);
      expect_word("short", 16'h0056, 2, 1'b0);
      @(negedge clk);

      // Invalid code inside a word, then a clean word
      push(8'h7F); push(8'h00); push(8'h6F); push(8'h3F);
      expect_word("invalid", 16'h8F90, 4, 1'b1);
      push(8'h06); push(8'h86);
      expect_word("after_invalid", 16'h0011, 2, 1'b0);
      @(negedge clk);

      // Backpressure with a pending code
      bus.out_ready = 1'b0;
      push(8'h3F); push(8'h06); push(8'h5B); push(8'h4F);
      expect_word("bp", 16'h0123, 4, 1'b0);
      held_bcd = bus.out_bcd;
      held_cnt = bus.out_count;
      bus.in_valid = 1'b1;
      bus.in_code  = 8'h87;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_bcd_stable", 32'(bus.out_bcd), 32'(held_bcd));
         chk("bp_count_stable", 32'(bus.out_count), 32'(held_cnt));
      end
      bus.out_ready = 1'b1;
      push(8'h87);
      expect_word("bp_next", 16'h0007, 1, 1'b0);
      @(negedge clk);

      // Exhaustive map, dp forced
      n_ok = 0;
      for (int i = 0; i < 256; i++) begin
         int d;
         code = 8'(i);
         d = map_code(code[6:0]);
         push(code | 8'h80);
         chk("map_count", 32'(bus.out_count), 32'd1);
         chk("map_err", 32'(bus.out_err), 32'(d < 0));
         chk("map_digit", 32'(bus.out_bcd[3:0]), 32'(d < 0 ? 15 : d));
         if (bus.out_valid && !bus.out_err) n_ok++;
      end
      chk("map_valid_total", 32'(n_ok), 32'd20);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
